printer_endpoint: RTL and testbench

PRINTER_ENDPOINT -- requirements
Module: printer_endpoint

---
 rtl/printer_pkg.sv | 14 +
 rtl/printer_fifo.sv | 50 +++++
 rtl/printer_endpoint.sv | 99 +++++++++
 tb/tb_printer_endpoint.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/printer_pkg.sv
// rtl/printer_pkg.sv - shared types and defaults for the printer endpoint
package printer_pkg;

  localparam int BYTE_W           = 8;
  localparam int DEF_PRINT_CYCLES = 16;
  localparam int DEF_FIFO_DEPTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRINT = 2'd1,
    ST_STALL = 2'd2
  } state_e;

endpackage

// File: rtl/printer_fifo.sv
// rtl/printer_fifo.sv - synchronous show-ahead byte FIFO for received print data
module printer_fifo
  import printer_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              pop,
  output logic [BYTE_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/printer_endpoint.sv
// rtl/printer_endpoint.sv - strobe-driven printer endpoint with busy timing and byte buffer
module printer_endpoint
  import printer_pkg::*;
#(
  parameter int PRINT_CYCLES = DEF_PRINT_CYCLES,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_request,
  input  logic [BYTE_W-1:0] print_data,
  output logic              print_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  input  logic              out_ready,
  output logic [15:0]       byte_count,
  output logic              overrun,
  input  logic              clr_err
);

  localparam int CW = $clog2(PRINT_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic           prev_q;
  logic           armed_q;
  logic [15:0]    byte_count_q;
  logic           overrun_q;

  logic           accept_ev;
  logic           push;
  logic           pop;
  logic           violate;
  logic           room_next;
  logic           fifo_full;
  logic           fifo_empty;
  logic [AW:0]    fifo_count;

  // armed_q blocks a strobe that was already high when reset released.
  assign accept_ev   = pulse_request && !prev_q && armed_q;
  assign print_ready = (state_q == ST_IDLE) && !fifo_full;
  assign push        = accept_ev && print_ready;
  assign violate     = accept_ev && !print_ready;
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign room_next   = (fifo_count != (AW+1)'(FIFO_DEPTH)) || pop;
  assign byte_count  = byte_count_q;
  assign overrun     = overrun_q;

  printer_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (print_data),
    .pop   (pop),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      prev_q       <= 1'b0;
      armed_q      <= 1'b0;
      byte_count_q <= 16'h0000;
      overrun_q    <= 1'b0;
    end else begin
      prev_q  <= pulse_request;
      armed_q <= armed_q | ~pulse_request;
      if (push) byte_count_q <= byte_count_q + 16'd1;
      // A new violation wins over a coincident clear.
      if (violate)      overrun_q <= 1'b1;
      else if (clr_err) overrun_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (push) begin
            cnt_q   <= CW'(PRINT_CYCLES - 1);
            state_q <= ST_PRINT;
          end
        end
        ST_PRINT: begin
          if (cnt_q == '0) state_q <= room_next ? ST_IDLE : ST_STALL;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_STALL: begin
          if (room_next) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_printer_endpoint.sv
// tb/tb_printer_endpoint.sv - self-checking bench for printer_endpoint
module tb_printer_endpoint;
  import printer_pkg::*;

  localparam int PC = 16;
  localparam int D  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pulse_request = 1'b0;
  logic [7:0]  print_data = 8'h00;
  logic        out_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic        print_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [15:0] byte_count;
  logic        overrun;

  int   errors = 0;
  int   checks = 0;
  logic preload_req = 1'b0;

  // Behavioural model: ready means "not printing and buffer has room".
  logic       m_prev = 1'b0;
  logic       m_armed = 1'b0;
  int         m_busy = 0;
  logic [7:0] m_q[$];
  logic [15:0] m_cnt = 16'h0000;
  logic       m_ovr = 1'b0;

  printer_endpoint dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pulse_request (pulse_request),
    .print_data    (print_data),
    .print_ready   (print_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .byte_count    (byte_count),
    .overrun       (overrun),
    .clr_err       (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return (m_busy == 0) && (m_q.size() < D);
  endfunction

  initial begin : model
    logic ev, rdy, popm;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_prev = 1'b0; m_armed = 1'b0; m_busy = 0;
        m_q.delete(); m_cnt = 16'h0000; m_ovr = 1'b0;
      end else begin
        ev   = pulse_request && !m_prev && m_armed;
        rdy  = m_ready();
        popm = out_ready && (m_q.size() > 0);
        if (popm) void'(m_q.pop_front());
        if (ev && rdy) begin
          m_q.push_back(print_data);
          m_cnt  = m_cnt + 16'd1;
          m_busy = PC;
        end else if (m_busy > 0) begin
          m_busy = m_busy - 1;
        end
        if (ev && !rdy)   m_ovr = 1'b1;
        else if (clr_err) m_ovr = 1'b0;
        if (preload_req) m_cnt = 16'hFFFF;
        m_armed = m_armed | !pulse_request;
        m_prev  = pulse_request;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      chk("m_print_ready", 32'(print_ready), 32'(m_ready()));
      chk("m_out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("m_out_data", 32'(out_data), 32'(m_q[0]));
      if (!preload_req) chk("m_byte_count", 32'(byte_count), 32'(m_cnt));
      chk("m_overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (print_ready !== 1'b1 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk(name, 32'(print_ready), 32'd1);
  endtask

  task automatic pulse(input logic [7:0] d);
    @(negedge clk);
    pulse_request = 1'b1;
    print_data    = d;
    @(negedge clk);
    pulse_request = 1'b0;
    #1;
  endtask

  task automatic pop_one();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk); out_ready = 1'b1;
    while (out_valid === 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    out_ready = 1'b0;
    #1;
    chk("drain_empty", 32'(out_valid), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int low;
    logic [15:0] b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_print_ready", 32'(print_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(print_ready), 32'd1);

    // Single byte
    pulse(8'h41);
    low = 0;
    while (print_ready === 1'b0 && low < 200) begin
      low++; @(negedge clk); #1;
    end
    chk("single_busy_cycles", 32'(low), 32'd16);
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data", 32'(out_data), 32'h41);
    chk("single_byte_count", 32'(byte_count), 32'd1);
    drain();

    // Burst filling the FIFO
    for (int i = 0; i < 8; i++) begin
      wait_ready("burst_wait");
      pulse(8'(i));
    end
    repeat (PC + 2) @(negedge clk);
    #1;
    chk("burst_state_stall", 32'(dut.state_q), 32'(ST_STALL));
    chk("burst_ready_low", 32'(print_ready), 32'd0);
    chk("burst_count", 32'(byte_count), 32'd9);
    chk("burst_head0", 32'(out_data), 32'h00);
    pop_one();
    chk("burst_ready_after_pop", 32'(print_ready), 32'd1);
    for (int i = 1; i < 8; i++) begin
      chk("burst_order", 32'(out_data), 32'(i));
      pop_one();
    end
    chk("burst_empty", 32'(out_valid), 32'd0);

    // Overrun: second strobe three cycles after the first
    wait_ready("ovr_wait");
    pulse(8'h55);
    @(negedge clk);
    pulse(8'h66);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_byte_count", 32'(byte_count), 32'd10);
    chk("ovr_head", 32'(out_data), 32'h55);
    pop_one();
    chk("ovr_one_byte", 32'(out_valid), 32'd0);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    #1;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    wait_ready("ovr_wait2");
    pulse(8'h77);
    @(negedge clk); pulse_request = 1'b1; clr_err = 1'b1;
    @(negedge clk); pulse_request = 1'b0; clr_err = 1'b0;
    #1;
    chk("ovr_set_beats_clr", 32'(overrun), 32'd1);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    drain();

    // Held strobe
    wait_ready("held_wait");
    b0 = byte_count;
    @(negedge clk); pulse_request = 1'b1; print_data = 8'h99;
    repeat (40) @(negedge clk);
    pulse_request = 1'b0;
    #1;
    chk("held_one_byte", 32'(byte_count), 32'(b0 + 16'd1));
    chk("held_no_overrun", 32'(overrun), 32'd0);
    drain();

    // Strobe already high at reset release
    @(negedge clk); rst_n = 1'b0; pulse_request = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("rel_high_no_event", 32'(byte_count), 32'd0);
    chk("rel_high_fifo", 32'(out_valid), 32'd0);
    @(negedge clk); pulse_request = 1'b0;
    pulse(8'h12);
    chk("rel_high_rearm", 32'(byte_count), 32'd1);
    drain();

    // Reset mid-print
    wait_ready("midrst_wait");
    pulse(8'hAA);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(print_ready), 32'd1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(byte_count), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("midrst_ready_after", 32'(print_ready), 32'd1);
    chk("midrst_empty_after", 32'(out_valid), 32'd0);

    // byte_count wrap
    wait_ready("wrap_wait");
    @(negedge clk);
    preload_req = 1'b1;
    force dut.byte_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.byte_count_q;
    preload_req = 1'b0;
    #1;
    chk("wrap_preload", 32'(byte_count), 32'hFFFF);
    pulse(8'h5A);
    chk("wrap_zero", 32'(byte_count), 32'h0000);
    chk("wrap_data", 32'(out_data), 32'h5A);
    chk("wrap_no_overrun", 32'(overrun), 32'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
